// File: rtl/axis_pattern_gen_pkg.sv
// Shared types, configuration field positions and LFSR helper for the
// AXI4-Stream pattern generator.
package axis_pattern_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } gen_state_t;

    localparam int CFG_EN_BIT  = 0;
    localparam int CFG_PAT_LSB = 1;
    localparam int CFG_LEN_LSB = 0;
    localparam int CFG_CNT_LSB = 16;

    localparam logic [1:0] PAT_COUNTER = 2'd0;
    localparam logic [1:0] PAT_LFSR    = 2'd1;
    localparam logic [1:0] PAT_CONST   = 2'd2;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // Right-shifting Galois form of x^32+x^22+x^2+x+1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] state);
        return state[0] ? ((state >> 1) ^ LFSR_POLY) : (state >> 1);
    endfunction

endpackage

// File: rtl/axis_pattern_lane_gen.sv
// Combinational beat calculator: first beat of a run from the seed, and the
// following beat from the current one.
module axis_pattern_lane_gen
    import axis_pattern_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [1:0]            cfg_pattern,
    input  logic [31:0]           cfg_seed,
    input  logic [1:0]            cur_pattern,
    input  logic [DATA_WIDTH-1:0] cur_beat,
    output logic [DATA_WIDTH-1:0] first_beat,
    output logic [DATA_WIDTH-1:0] next_beat
);

    localparam int LANES = DATA_WIDTH / 32;

    logic [31:0] first_lfsr;
    logic [31:0] next_lfsr;

    always_comb begin
        first_beat = '0;
        first_lfsr = (cfg_seed == 32'd0) ? 32'd1 : cfg_seed;
        for (int k = 0; k < LANES; k++) begin
            case (cfg_pattern)
                PAT_COUNTER: first_beat[32*k +: 32] = cfg_seed + 32'(k);
                PAT_LFSR:    first_beat[32*k +: 32] = first_lfsr;
                default:     first_beat[32*k +: 32] = cfg_seed;
            endcase
            first_lfsr = lfsr_step(first_lfsr);
        end
    end

    // The LFSR sequence continues from the top lane of the current beat.
    always_comb begin
        next_beat = '0;
        next_lfsr = cur_beat[DATA_WIDTH-1 -: 32];
        for (int k = 0; k < LANES; k++) begin
            next_lfsr = lfsr_step(next_lfsr);
            case (cur_pattern)
                PAT_COUNTER: next_beat[32*k +: 32] = cur_beat[32*k +: 32] + 32'(LANES);
                PAT_LFSR:    next_beat[32*k +: 32] = next_lfsr;
                default:     next_beat[32*k +: 32] = cur_beat[32*k +: 32];
            endcase
        end
    end

endmodule

// File: rtl/axis_pattern_gen.sv
// Packetised AXI4-Stream pattern generator driven by three software
// configuration words; handles start detection, shadowing and backpressure.
module axis_pattern_gen
    import axis_pattern_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                    axi_clk,
    input  logic                    axi_rstn,
    input  logic [31:0]             config_reg0,
    input  logic [31:0]             config_reg1,
    input  logic [31:0]             config_reg2,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    gen_busy,
    output logic                    gen_done,
    output logic [31:0]             pkt_sent
);

    gen_state_t  state;
    logic        en_q;
    logic        armed;
    logic [15:0] len_q;
    logic [15:0] count_q;
    logic [1:0]  pattern_q;
    logic [15:0] beat_cnt;

    logic                  cfg_enable;
    logic [1:0]            cfg_pattern;
    logic [15:0]           cfg_len;
    logic                  start;
    logic                  handshake;
    logic [15:0]           beat_nxt;
    logic [31:0]           pkt_nxt;
    logic [DATA_WIDTH-1:0] first_beat;
    logic [DATA_WIDTH-1:0] next_beat;
    logic                  unused_cfg;

    assign cfg_enable  = config_reg0[CFG_EN_BIT];
    assign cfg_pattern = config_reg0[CFG_PAT_LSB +: 2];
    assign cfg_len     = config_reg1[CFG_LEN_LSB +: 16];
    // armed blocks a start from an enable level that was already high at reset release.
    assign start       = cfg_enable & ~en_q & armed;
    assign handshake   = m_axis_tvalid & m_axis_tready;
    assign beat_nxt    = beat_cnt + 16'd1;
    assign pkt_nxt     = pkt_sent + 32'd1;
    assign unused_cfg  = ^config_reg0[31:3];

    axis_pattern_lane_gen #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_lane_gen (
        .cfg_pattern(cfg_pattern),
        .cfg_seed   (config_reg2),
        .cur_pattern(pattern_q),
        .cur_beat   (m_axis_tdata),
        .first_beat (first_beat),
        .next_beat  (next_beat)
    );

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state         <= ST_IDLE;
            en_q          <= 1'b0;
            armed         <= 1'b0;
            len_q         <= 16'd1;
            count_q       <= '0;
            pattern_q     <= PAT_CONST;
            beat_cnt      <= '0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            gen_busy      <= 1'b0;
            gen_done      <= 1'b0;
            pkt_sent      <= '0;
        end else begin
            en_q <= cfg_enable;
            if (!cfg_enable) begin
                armed <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_q         <= (cfg_len == 16'd0) ? 16'd1 : cfg_len;
                        count_q       <= config_reg1[CFG_CNT_LSB +: 16];
                        pattern_q     <= cfg_pattern;
                        beat_cnt      <= '0;
                        pkt_sent      <= '0;
                        m_axis_tdata  <= first_beat;
                        m_axis_tkeep  <= '1;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= (cfg_len <= 16'd1);
                        gen_busy      <= 1'b1;
                        state         <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (handshake) begin
                        m_axis_tdata <= next_beat;
                        if (m_axis_tlast) begin
                            pkt_sent <= pkt_nxt;
                            beat_cnt <= '0;
                            if ((count_q != 16'd0) && (pkt_nxt == {16'd0, count_q})) begin
                                m_axis_tvalid <= 1'b0;
                                m_axis_tkeep  <= '0;
                                m_axis_tlast  <= 1'b0;
                                gen_busy      <= 1'b0;
                                gen_done      <= 1'b1;
                                state         <= ST_DONE;
                            end else if (!cfg_enable) begin
                                m_axis_tvalid <= 1'b0;
                                m_axis_tkeep  <= '0;
                                m_axis_tlast  <= 1'b0;
                                gen_busy      <= 1'b0;
                                state         <= ST_IDLE;
                            end else begin
                                m_axis_tlast <= (len_q == 16'd1);
                            end
                        end else begin
                            beat_cnt     <= beat_nxt;
                            m_axis_tlast <= (beat_nxt == len_q - 16'd1);
                        end
                    end
                end
                ST_DONE: begin
                    if (!cfg_enable) begin
                        gen_done <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Directed bench for axis_pattern_gen: an independent model fills a scoreboard
// that a negedge monitor drains on every handshake.
module tb_axis_pattern_gen;

    localparam int DATA_WIDTH = 64;
    localparam int KEEP_W     = DATA_WIDTH / 8;

    logic                  axi_clk = 1'b0;
    logic                  axi_rstn;
    logic [31:0]           config_reg0;
    logic [31:0]           config_reg1;
    logic [31:0]           config_reg2;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic [KEEP_W-1:0]     m_axis_tkeep;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;
    logic                  gen_busy;
    logic                  gen_done;
    logic [31:0]           pkt_sent;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } beat_t;

    beat_t       sb[$];
    beat_t       exp_beat;
    int          checks     = 0;
    int          errors     = 0;
    int          hs_count   = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data  = '0;
    logic        prev_last  = 1'b0;

    axis_pattern_gen #(
        .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .axi_clk      (axi_clk),
        .axi_rstn     (axi_rstn),
        .config_reg0  (config_reg0),
        .config_reg1  (config_reg1),
        .config_reg2  (config_reg2),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .gen_busy     (gen_busy),
        .gen_done     (gen_done),
        .pkt_sent     (pkt_sent)
    );

    always #5 axi_clk = ~axi_clk;

    // Reference LFSR written bit by bit from the tap positions 31, 21, 1, 0.
    function automatic logic [31:0] lfsr_ref(input logic [31:0] s);
        logic [31:0] n;
        n     = {1'b0, s[31:1]};
        n[31] = s[0];
        n[21] = s[22] ^ s[0];
        n[1]  = s[2] ^ s[0];
        n[0]  = s[1] ^ s[0];
        return n;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2);
        @(posedge axi_clk);
        #1;
        config_reg1 = r1;
        config_reg2 = r2;
        config_reg0 = r0;
    endtask

    task automatic stopEnable();
        @(posedge axi_clk);
        #1;
        config_reg0[0] = 1'b0;
    endtask

    task automatic pushCounter(input logic [31:0] seed, input int beats, input int len);
        beat_t b;
        for (int n = 0; n < beats; n++) begin
            b.data = {seed + 32'(2 * n + 1), seed + 32'(2 * n)};
            b.last = ((n % len) == len - 1);
            sb.push_back(b);
        end
    endtask

    task automatic waitDone(input string tag);
        int n = 0;
        while (!gen_done && n < 500) begin
            @(negedge axi_clk);
            n++;
        end
        checkOutput(tag, 64'(gen_done), 64'd1);
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (gen_busy && n < 500) begin
            @(negedge axi_clk);
            n++;
        end
        checkOutput(tag, 64'(gen_busy), 64'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
        checkOutput({tag, "_tdata"}, m_axis_tdata, 64'd0);
        checkOutput({tag, "_tkeep"}, 64'(m_axis_tkeep), 64'd0);
        checkOutput({tag, "_tlast"}, 64'(m_axis_tlast), 64'd0);
        checkOutput({tag, "_busy"}, 64'(gen_busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(gen_done), 64'd0);
        checkOutput({tag, "_pkt_sent"}, 64'(pkt_sent), 64'd0);
    endtask

    // Monitor: stall stability, tkeep, and scoreboard comparison per handshake.
    always @(negedge axi_clk) begin
        if (!axi_rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("hold_tvalid", 64'(m_axis_tvalid), 64'd1);
                checkOutput("hold_tdata", m_axis_tdata, prev_data);
                checkOutput("hold_tlast", 64'(m_axis_tlast), 64'(prev_last));
            end
            if (m_axis_tvalid) begin
                checkOutput("tkeep", 64'(m_axis_tkeep), 64'hFF);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                hs_count++;
                checkOutput("beat_expected", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    exp_beat = sb.pop_front();
                    checkOutput("beat_tdata", m_axis_tdata, exp_beat.data);
                    checkOutput("beat_tlast", 64'(m_axis_tlast), 64'(exp_beat.last));
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int    base;
        int    n;
        beat_t b;
        logic [31:0] s;

        axi_rstn      = 1'b0;
        config_reg0   = '0;
        config_reg1   = '0;
        config_reg2   = '0;
        m_axis_tready = 1'b1;
        #3;
        checkAllZero("reset");
        repeat (2) @(posedge axi_clk);
        #1 axi_rstn = 1'b1;
        repeat (2) @(posedge axi_clk);

        $display("[TB] counter pattern, 2 packets of 4 beats");
        pushCounter(32'h100, 8, 4);
        applyStimulus(32'h1, 32'h0002_0004, 32'h100);
        @(posedge axi_clk);
        @(negedge axi_clk);
        checkOutput("first_valid_latency", 64'(m_axis_tvalid), 64'd1);
        checkOutput("busy_in_send", 64'(gen_busy), 64'd1);
        waitDone("ctr_done");
        checkOutput("ctr_pkt_sent", 64'(pkt_sent), 64'd2);
        checkOutput("ctr_valid_in_done", 64'(m_axis_tvalid), 64'd0);
        checkOutput("ctr_sb_empty", 64'(sb.size()), 64'd0);
        stopEnable();
        @(posedge axi_clk);
        @(negedge axi_clk);
        checkOutput("done_clears", 64'(gen_done), 64'd0);

        $display("[TB] counter pattern under random backpressure");
        pushCounter(32'h100, 8, 4);
        applyStimulus(32'h1, 32'h0002_0004, 32'h100);
        n = 0;
        while (!gen_done && n < 400) begin
            @(posedge axi_clk);
            #1 m_axis_tready = 1'($urandom_range(0, 1));
            n++;
        end
        m_axis_tready = 1'b1;
        checkOutput("bp_done", 64'(gen_done), 64'd1);
        checkOutput("bp_pkt_sent", 64'(pkt_sent), 64'd2);
        checkOutput("bp_sb_empty", 64'(sb.size()), 64'd0);
        stopEnable();
        repeat (2) @(posedge axi_clk);

        $display("[TB] graceful stop on unlimited run");
        pushCounter(32'h2000, 4, 4);
        applyStimulus(32'h1, 32'h0000_0004, 32'h2000);
        base = hs_count;
        n = 0;
        while (hs_count < base + 2 && n < 100) begin
            @(negedge axi_clk);
            n++;
        end
        @(posedge axi_clk);
        #1 config_reg0[0] = 1'b0;
        waitIdle("gs_idle");
        checkOutput("gs_pkt_sent", 64'(pkt_sent), 64'd1);
        checkOutput("gs_valid_low", 64'(m_axis_tvalid), 64'd0);
        checkOutput("gs_not_done", 64'(gen_done), 64'd0);
        repeat (5) @(negedge axi_clk);
        checkOutput("gs_beats", 64'(hs_count - base), 64'd4);
        checkOutput("gs_sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] zero length, constant pattern");
        b.data = 64'hA5A5A5A5_A5A5A5A5;
        b.last = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back(b);
        applyStimulus(32'h5, 32'h0003_0000, 32'hA5A5_A5A5);
        waitDone("zl_done");
        checkOutput("zl_pkt_sent", 64'(pkt_sent), 64'd3);
        checkOutput("zl_sb_empty", 64'(sb.size()), 64'd0);
        stopEnable();
        repeat (2) @(posedge axi_clk);

        $display("[TB] LFSR pattern with seed 0");
        b.data = {32'h8020_0003, 32'h0000_0001};
        b.last = 1'b0;
        sb.push_back(b);
        s = lfsr_ref(lfsr_ref(32'h1));
        for (int i = 1; i < 4; i++) begin
            b.data[31:0]  = s;
            s = lfsr_ref(s);
            b.data[63:32] = s;
            s = lfsr_ref(s);
            b.last = (i == 3);
            sb.push_back(b);
        end
        applyStimulus(32'h3, 32'h0001_0004, 32'h0);
        waitDone("lfsr_done");
        checkOutput("lfsr_pkt_sent", 64'(pkt_sent), 64'd1);
        checkOutput("lfsr_sb_empty", 64'(sb.size()), 64'd0);
        stopEnable();
        repeat (2) @(posedge axi_clk);

        $display("[TB] reset asserted mid-packet");
        pushCounter(32'h5000, 40, 4);
        applyStimulus(32'h1, 32'h0000_0004, 32'h5000);
        base = hs_count;
        n = 0;
        while (hs_count < base + 5 && n < 100) begin
            @(negedge axi_clk);
            n++;
        end
        @(posedge axi_clk);
        #3 axi_rstn = 1'b0;
        #1;
        checkAllZero("midrst");
        sb.delete();
        @(posedge axi_clk);
        #1 axi_rstn = 1'b1;
        repeat (10) @(negedge axi_clk);
        checkOutput("held_en_no_start_valid", 64'(m_axis_tvalid), 64'd0);
        checkOutput("held_en_no_start_busy", 64'(gen_busy), 64'd0);
        stopEnable();
        pushCounter(32'h7000, 4, 4);
        applyStimulus(32'h1, 32'h0001_0004, 32'h7000);
        waitDone("restart_done");
        checkOutput("restart_pkt_sent", 64'(pkt_sent), 64'd1);
        checkOutput("restart_sb_empty", 64'(sb.size()), 64'd0);
        stopEnable();
        repeat (2) @(posedge axi_clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_pattern_gen.md
# axis_pattern_gen

Configurable AXI4-Stream test-data generator sitting directly downstream of the AXI-Lite configuration slave in the XDMA streaming datapath. It consumes the three 32-bit configuration words (`config_reg0..2`) and emits packetised pattern data toward the XDMA C2H stream input. Packet length, packet count, pattern type and seed come from software; the stream obeys full AXI4-Stream backpressure.

## Interface
- `DATA_WIDTH`, 64: stream width in bits; multiple of 32; `L = DATA_WIDTH/32` lanes.
- `axi_clk`  in  1  sole clock.
- `axi_rstn`  in  1  asynchronous, active-low reset.
- `config_reg0`  in  32  [0] enable (level); [2:1] pattern: 0 counter, 1 LFSR, 2 constant, 3 reserved (treated as constant).
- `config_reg1`  in  32  [15:0] beats per packet; [31:16] packet count (0 = unlimited).
- `config_reg2`  in  32  seed / constant value.
- `m_axis_tdata`  out  DATA_WIDTH  stream data.
- `m_axis_tkeep`  out  DATA_WIDTH/8  all ones whenever tvalid=1; 0 otherwise.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  last beat of packet.
- `gen_busy`  out  1  high in SEND.
- `gen_done`  out  1  high in DONE.
- `pkt_sent`  out  32  packets completed since last start.

## Operation
- States: IDLE, SEND, DONE.
- `en_q` registers `config_reg0[0]`; start = `config_reg0[0] & ~en_q` (rising edge only; a level held high through reset does not start).
- IDLE: on start, latch shadow copies of len (0 → 1), count, pattern, seed; clear beat/packet counters and `pkt_sent`; load beat 0 into tdata; set tvalid; go SEND.
- SEND: handshake = tvalid & tready. On handshake advance data to next beat; beat_cnt++. On handshake with tlast: `pkt_sent`++, beat_cnt ← 0; then
  - count≠0 and packets done == count → DONE, tvalid ← 0.
  - enable currently low → IDLE, tvalid ← 0 (graceful stop at packet boundary).
  - else continue next packet.
- Enable falling mid-packet never truncates: packet completes through tlast.
- DONE: tvalid 0, `gen_done` 1; leaves to IDLE when enable low. Restart requires a new rising edge.
- Config changes during SEND/DONE are ignored (shadowed).
- Patterns, beat index n counts continuously across packets of one run, lane k = bits [32k+31:32k]:
  - counter: seed + n·L + k, modulo 2^32.
  - LFSR: Galois, polynomial x^32+x^22+x^2+x+1 (0x80200003); state starts at seed (0 → 1); lane k of beat n = state after n·L+k steps (lane 0 beat 0 = seed).
  - constant: every lane = seed.
- `pkt_sent` wraps at 2^32; retained until next start.

## Timing
- Reset (async assert, sync-released use): state IDLE; tdata 0, tkeep 0, tvalid 0, tlast 0, gen_busy 0, gen_done 0, pkt_sent 0, en_q 0.
- Reset asserted mid-packet: outputs drop immediately, no completion of the packet.
- First tvalid: cycle after the cycle in which enable is first sampled high.
- Throughput: one beat per cycle with tready held high; no bubbles between packets.
- tlast is registered, high exactly on beat len−1 of each packet.
- While tvalid=1 and tready=0: tdata, tkeep, tlast held stable; tvalid never deasserted without a handshake.
- Packet count reached and enable falling on the same final beat: go DONE.

## Structure
- Package `axis_pattern_gen_pkg`: state enum, config field bit positions, pattern codes, LFSR polynomial constant, one-step LFSR function.
- Sub-module `axis_pattern_lane_gen`: combinational next-beat calculator (current lane values + pattern → next beat); top holds FSM, counters, handshake.

## Test plan
- Reset: drive axi_rstn low mid-run → all outputs 0 within the same cycle, no clock edge needed; re-assert with enable still high → no traffic until enable toggles.
- Counter, DATA_WIDTH=64, reg1=0x0002_0004, reg2=0x100, tready=1 → 8 beats, beat0 {0x101,0x100}, beat7 {0x10F,0x10E}, tlast on beats 3 and 7, then gen_done=1, pkt_sent=2.
- Backpressure: same config, tready random 50% → identical beat sequence; tdata/tlast stable while stalled; tvalid never drops before handshake.
- Graceful stop: reg1=0x0000_0004 (unlimited), drop enable after beat 1 → beats 2, 3 still sent, tlast on beat 3, then IDLE, pkt_sent=1.
- Zero length: reg1=0x0003_0000, constant 0xA5A5A5A5 → 3 beats, each tlast=1, data 0xA5A5A5A5_A5A5A5A5.
- LFSR seed 0: pattern 1, reg2=0 → lane0 beat0 = 0x00000001, lane1 beat0 = 0x80200003, matches reference model.
